// File: rtl/timer_pkg.sv
// Shared types and default sizes for the interval timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } timer_state_t;

  localparam int unsigned DEFAULT_WIDTH      = 32;
  localparam int unsigned DEFAULT_PRESCALE_W = 20;

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider: counts enabled clocks and strobes once every (prescale + 1) of them.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick,
  output logic                  o_wrap
);

  localparam logic [PRESCALE_W-1:0] PreOne = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] r_pre;
  logic                  r_tick;
  logic                  w_wrap;

  // clr wins over counting so a restart or stop never lets a strobe through.
  assign w_wrap = i_en & ~i_clr & (r_pre == i_prescale);
  assign o_wrap = w_wrap;
  assign o_tick = r_tick;

  // Divider count and registered tick strobe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (i_clr) begin
        r_pre <= '0;
      end else if (i_en) begin
        r_pre <= w_wrap ? '0 : r_pre + PreOne;
      end
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: start/stop/pause FSM, captured configuration,
// tick counter with terminal-count compare, one-shot or auto-reload expiry.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned PRESCALE_W = DEFAULT_PRESCALE_W
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_pause,
  input  logic                  i_periodic,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic [WIDTH-1:0]      i_period,
  output logic                  o_busy,
  output logic                  o_tick,
  output logic                  o_expire,
  output logic [WIDTH-1:0]      o_val
);

  localparam logic [WIDTH-1:0] ValOne = {{(WIDTH-1){1'b0}}, 1'b1};

  timer_state_t r_state, w_state_next;

  logic [PRESCALE_W-1:0] r_prescale_s;
  logic [WIDTH-1:0]      r_period_s;
  logic                  r_periodic_s;
  logic [WIDTH-1:0]      r_val;
  logic                  r_expire;
  logic                  r_busy;

  logic w_accept_start;
  logic w_clr;
  logic w_en;
  logic w_wrap;
  logic w_tick;
  logic w_expire_due;

  assign w_accept_start = i_start & ~i_stop;
  assign w_clr          = i_stop | w_accept_start;
  // A PAUSED edge with pause released counts, so pause costs exactly its high cycles.
  assign w_en           = (r_state != IDLE) & ~i_pause;
  assign w_expire_due   = w_wrap & (r_val == r_period_s);

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_prescaler (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (w_clr),
    .i_en       (w_en),
    .i_prescale (r_prescale_s),
    .o_tick     (w_tick),
    .o_wrap     (w_wrap)
  );

  // Next-state decode: stop beats start, start beats pause/expiry.
  always_comb begin
    w_state_next = r_state;
    if (i_stop) begin
      w_state_next = IDLE;
    end else if (i_start) begin
      if (r_state == IDLE) begin
        w_state_next = RUN;
      end else begin
        w_state_next = i_pause ? PAUSED : RUN;
      end
    end else begin
      unique case (r_state)
        IDLE: w_state_next = IDLE;
        RUN, PAUSED: begin
          if (i_pause) begin
            w_state_next = PAUSED;
          end else if (w_expire_due && !r_periodic_s) begin
            w_state_next = IDLE;
          end else begin
            w_state_next = RUN;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State register plus registered busy.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
    end
  end

  // Shadow configuration, loaded only when a start is accepted.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prescale_s <= '0;
      r_period_s   <= '0;
      r_periodic_s <= 1'b0;
    end else if (w_accept_start) begin
      r_prescale_s <= i_prescale;
      r_period_s   <= i_period;
      r_periodic_s <= i_periodic;
    end
  end

  // Tick counter and expiry strobe; val holds across stop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_val    <= '0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= w_expire_due;
      if (w_accept_start) begin
        r_val <= '0;
      end else if (w_wrap) begin
        r_val <= w_expire_due ? '0 : r_val + ValOne;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_tick   = w_tick;
  assign o_expire = r_expire;
  assign o_val    = r_val;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl: vector table plus corner-case sequences.
module tb_interval_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, pause, periodic;
  logic [19:0] prescale;
  logic [31:0] period;
  logic        busy, tick, expire;
  logic [31:0] val;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        start;
    logic        stop;
    logic        pause;
    logic        periodic;
    logic [19:0] prescale;
    logic [31:0] period;
    logic        busy;
    logic        tick;
    logic        expire;
    logic [31:0] val;
  } vec_t;

  vec_t vecs[17];

  interval_timer_ctrl #(
    .WIDTH      (32),
    .PRESCALE_W (20)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_stop     (stop),
    .i_pause    (pause),
    .i_periodic (periodic),
    .i_prescale (prescale),
    .i_period   (period),
    .o_busy     (busy),
    .o_tick     (tick),
    .o_expire   (expire),
    .o_val      (val)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic st, input logic p, input logic per,
                              input logic [19:0] pre, input logic [31:0] prd,
                              input logic b, input logic t, input logic e,
                              input logic [31:0] v);
    vec_t r;
    r.start = s; r.stop = st; r.pause = p; r.periodic = per;
    r.prescale = pre; r.period = prd;
    r.busy = b; r.tick = t; r.expire = e; r.val = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic b, input logic t, input logic e,
                           input logic [31:0] v);
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, ".tick"}, {31'd0, tick}, {31'd0, t});
    check({tag, ".expire"}, {31'd0, expire}, {31'd0, e});
    check({tag, ".val"}, val, v);
  endtask

  task automatic set_in(input logic s, input logic st, input logic p, input logic per,
                        input logic [19:0] pre, input logic [31:0] prd);
    start = s; stop = st; pause = p; periodic = per; prescale = pre; period = prd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_exp;
    int second_exp;

    // One-shot prescale=3 period=2: ticks at E4, E8, E12; expiry and busy drop at E12.
    vecs[0]  = mk(1, 0, 0, 0, 3, 2, 1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // One-shot prescale=0 period=0: expires on the very first tick.
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    #12;
    check_out("reset", 0, 0, 0, 0);
    reset = 1'b0;
    step();
    check_out("post_reset", 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].periodic,
             vecs[i].prescale, vecs[i].period);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].busy, vecs[i].tick, vecs[i].expire, vecs[i].val);
    end

    // Periodic prescale=0 period=4: tick every cycle, expire every 5th.
    set_in(1, 0, 0, 1, 0, 4);
    step();
    check_out("per_start", 1, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      check_out($sformatf("per_k%0d", k), 1, 1, (k % 5) == 0, k % 5);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_out("per_stop", 0, 0, 0, 0);

    // Periodic prescale=1 period=3 with pause over E4..E9: expiries at E14, E22.
    set_in(1, 0, 0, 1, 1, 3);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    first_exp  = 0;
    second_exp = 0;
    for (int k = 1; k <= 25; k++) begin
      pause = (k >= 4 && k <= 9);
      step();
      if (expire && first_exp == 0) first_exp = k;
      else if (expire && second_exp == 0) second_exp = k;
      if (k >= 4 && k <= 9) begin
        check($sformatf("pause_k%0d.val", k), val, 1);
        check($sformatf("pause_k%0d.tick", k), {31'd0, tick}, 0);
        check($sformatf("pause_k%0d.busy", k), {31'd0, busy}, 1);
      end
    end
    pause = 1'b0;
    check("pause_first_expire", first_exp, 14);
    check("pause_second_expire", second_exp, 22);
    check("pause_val_before_stop", val, 1);

    // stop and start together on an edge where a tick was due: stop wins.
    set_in(1, 1, 0, 0, 5, 9);
    step();
    check_out("stopstart", 0, 0, 0, 1);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    check_out("stopstart_idle", 0, 0, 0, 1);

    // Restart mid-run with period=1 on an edge where a tick was due.
    set_in(1, 0, 0, 0, 2, 5);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) step();
    check("restart_pre_val", val, 2);
    set_in(1, 0, 0, 0, 2, 1);
    step();
    check_out("restart_edge", 1, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 8; j++) begin
      step();
      check_out($sformatf("restart_j%0d", j), j < 6, ((j % 3) == 0) && (j <= 6), j == 6,
                (j >= 3 && j < 6) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset between edges with val=7.
    set_in(1, 0, 0, 1, 0, 20);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    repeat (7) step();
    check_out("pre_async", 1, 1, 0, 7);
    #3;
    reset = 1'b1;
    #1;
    check_out("async_reset", 0, 0, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_out($sformatf("after_reset%0d", k), 0, 0, 0, 0);
    end
    set_in(1, 0, 0, 0, 0, 1);
    step();
    check_out("rs_start", 1, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    check_out("rs_e1", 1, 1, 0, 1);
    step();
    check_out("rs_e2", 0, 1, 1, 0);
    step();
    check_out("rs_e3", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interval_timer_ctrl.md
# interval_timer_ctrl

Programmable interval timer controller that sequences a prescaled free-running count into one-shot or periodic expirations. It holds the prescaler and terminal-count configuration and runs a start/stop/pause state machine. It emits a per-tick strobe and an expiry strobe for downstream logic such as display refresh, debouncing and sampling. It replaces fixed bit-slice timebases with a runtime-programmable one.

## Interface
Parameters:
- WIDTH, 32, width of count value and period
- PRESCALE_W, 20, width of prescale divider field

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  start/restart request, sampled each rising edge
- stop  in  1  stop request; priority over start and pause
- pause  in  1  level; freezes counting while high in RUN
- periodic  in  1  mode select, captured on accepted start (1 = auto-reload)
- prescale  in  PRESCALE_W  clocks per tick minus 1, captured on accepted start
- period  in  WIDTH  terminal count, captured on accepted start
- busy  out  1  high in RUN or PAUSED
- tick  out  1  one-cycle strobe per prescaled tick
- expire  out  1  one-cycle strobe on terminal count
- val  out  WIDTH  current tick count

## Operation
- States: IDLE, RUN, PAUSED.
- IDLE + start -> RUN. Capture prescale, period and periodic into shadow registers. Clear pre and val.
- RUN + start (no stop) -> restart. Recapture shadows and clear pre/val. Any tick or expire due on that edge is suppressed.
- stop in any state -> IDLE. val holds its last value, pre clears, tick/expire are not asserted. stop+start on the same edge: stop wins.
- RUN + pause -> PAUSED. pre and val freeze, with no tick that edge. PAUSED + !pause -> RUN. PAUSED + start -> restart into RUN, or into PAUSED if pause is still high.
- In RUN, pre increments each clock. When pre == prescale_s: pre <- 0 and tick <= 1.
  - If val == period_s: val <- 0 and expire <= 1. Periodic stays in RUN; one-shot goes to IDLE on the same edge.
  - Otherwise val <- val + 1.
- prescale = 0: tick every RUN cycle. period = 0: expire on every tick.
- val arithmetic is unsigned WIDTH bits. It cannot wrap because the compare occurs at period_s ≤ 2^WIDTH−1.
- Configuration inputs are ignored except on accepted start; changing them mid-run has no effect.
- Reset values: state IDLE, busy 0, tick 0, expire 0, val 0, pre 0, shadows 0.

## Timing
- All outputs are registered. No combinational input-to-output paths.
- start sampled at edge E0: busy = 1 and val = 0 from E0.
- First tick is high during the cycle following edge E(prescale+1).
- Expire interval = (period+1)·(prescale+1) clocks of RUN. PAUSED cycles extend it one-for-one.
- One-shot: busy falls on the same edge where expire rises.
- tick and expire are never high for 2 consecutive cycles unless prescale = 0.
- Reset asserted mid-run: outputs go to reset values immediately, without waiting for a clock edge. The first start after release behaves as from IDLE.

## Structure
- Package timer_pkg:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, PAUSED}
  - default WIDTH/PRESCALE_W constants
- Sub-module tick_prescaler:
  - Inputs: clk, reset, clr, en, prescale.
  - Output: registered tick strobe.
- Top-level content: FSM, shadow registers, val counter and compare.

## Test plan
- Reset then start with prescale=3, period=2, periodic=0 -> tick at cycles 4, 8, 12 after start. val goes 1, 2, 0. expire with tick at cycle 12, busy falls same edge.
- Periodic, prescale=0, period=4 -> expire every 5 cycles across 4 intervals. tick every cycle, busy held high.
- Periodic, prescale=1, period=3, pause held 6 cycles mid-run -> val and tick frozen during pause. First expire delayed by exactly 6 cycles vs. reference timing.
- stop and start asserted on the same edge during RUN -> IDLE, busy 0, val holds last value, no tick/expire.
- start re-asserted mid-run with new period=1 -> val clears. Next expire at (1+1)·(prescale+1) cycles after restart. No strobe on the restart edge.
- Assert reset asynchronously between clock edges during RUN with val=7 -> busy, val, tick and expire go to 0 before the next edge. Timer idles until a new start.
